// File: rtl/dll_fc_pkg.sv
// rtl/dll_fc_pkg.sv - shared types and constants for the DLL rx flow-control tracker
// Purpose: FC type, DLLP type codes, DLCMSM encodings, FC init FSM states and
//          DLLP field positions used by dll_rx_fc_tracker and dll_fc_credit_slot.
// Ports:   none (package)
package dll_fc_pkg;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_e;

  typedef enum logic [1:0] {
    DLC_INACTIVE  = 2'b00,
    DLC_FEATURE   = 2'b01,
    DLC_DL_INIT   = 2'b10,
    DLC_DL_ACTIVE = 2'b11
  } dlc_state_e;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_INIT1 = 2'd1,
    FC_INIT2 = 2'd2,
    FC_DONE  = 2'd3
  } fc_fsm_e;

  // Upper two bits of the DLLP type select the FC message class,
  // lower two bits select the FC type (11 is not a tracked type).
  localparam logic [1:0] DLLP_CLS_INITFC1 = 2'b01;
  localparam logic [1:0] DLLP_CLS_UPDATEFC = 2'b10;
  localparam logic [1:0] DLLP_CLS_INITFC2 = 2'b11;

  localparam int DLLP_TYPE_MSB = 63;
  localparam int DLLP_TYPE_LSB = 60;
  localparam int DLLP_VC_MSB   = 58;
  localparam int DLLP_VC_LSB   = 56;
  localparam int HDRFC_MSB     = 53;
  localparam int HDRFC_LSB     = 46;
  localparam int DATAFC_MSB    = 43;
  localparam int DATAFC_LSB    = 32;

endpackage

// File: rtl/dll_rx_fc_tracker_if.sv
// rtl/dll_rx_fc_tracker_if.sv - DLLP input and TX request/grant bundle
// Purpose: groups the DLLP receive stream and the TX arbiter request/grant
//          handshake. master = DLLP demux + arbiter side, slave = tracker.
// Ports:   dllp_i/dllp_valid_i/dllp_crc_ok_i (DLLP in), tx_req_* (request),
//          tx_grant_o (grant back to arbiter)
interface dll_rx_fc_tracker_if #(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 12
);
  logic [135:0]      dllp_i;
  logic              dllp_valid_i;
  logic              dllp_crc_ok_i;
  logic              tx_req_i;
  logic [1:0]        tx_req_type_i;
  logic [HDR_W-1:0]  tx_req_hdr_i;
  logic [DATA_W-1:0] tx_req_data_i;
  logic              tx_grant_o;

  modport master (
    output dllp_i, dllp_valid_i, dllp_crc_ok_i,
    output tx_req_i, tx_req_type_i, tx_req_hdr_i, tx_req_data_i,
    input  tx_grant_o
  );

  modport slave (
    input  dllp_i, dllp_valid_i, dllp_crc_ok_i,
    input  tx_req_i, tx_req_type_i, tx_req_hdr_i, tx_req_data_i,
    output tx_grant_o
  );
endinterface

// File: rtl/dll_fc_credit_slot.sv
// rtl/dll_fc_credit_slot.sv - credit limit / consumed tracking for one FC type
// Purpose: holds CL, CC, infinite and loaded flags for one FC type and
//          evaluates whether a request fits the advertised credits.
// Ports:   clk, rst_n; clr (link down); load (InitFC1), upd (honoured UpdateFC)
//          with fc_hdr/fc_data; consume with req_hdr/req_data;
//          cl_*/inf_*/loaded state out; hdr_ok/data_ok; upd_err (infinite violated)
module dll_fc_credit_slot #(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              upd,
  input  logic [HDR_W-1:0]  fc_hdr,
  input  logic [DATA_W-1:0] fc_data,
  input  logic              consume,
  input  logic [HDR_W-1:0]  req_hdr,
  input  logic [DATA_W-1:0] req_data,
  output logic [HDR_W-1:0]  cl_hdr,
  output logic [DATA_W-1:0] cl_data,
  output logic              inf_hdr,
  output logic              inf_data,
  output logic              loaded,
  output logic              hdr_ok,
  output logic              data_ok,
  output logic              upd_err
);

  localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

  logic [HDR_W-1:0]  cc_hdr;
  logic [DATA_W-1:0] cc_data;
  logic [HDR_W-1:0]  hdr_room;
  logic [DATA_W-1:0] data_room;

  // Modular distance: a result in the upper half means the request would
  // overrun the limit, which keeps the check correct across counter wrap.
  assign hdr_room  = cl_hdr - cc_hdr - req_hdr;
  assign data_room = cl_data - cc_data - req_data;
  assign hdr_ok    = inf_hdr | (hdr_room <= HDR_HALF);
  assign data_ok   = inf_data | (data_room <= DATA_HALF);

  assign upd_err = upd & ((inf_hdr & (fc_hdr != '0)) | (inf_data & (fc_data != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl_hdr   <= '0;
      cl_data  <= '0;
      cc_hdr   <= '0;
      cc_data  <= '0;
      inf_hdr  <= 1'b0;
      inf_data <= 1'b0;
      loaded   <= 1'b0;
    end else if (clr) begin
      cl_hdr   <= '0;
      cl_data  <= '0;
      cc_hdr   <= '0;
      cc_data  <= '0;
      inf_hdr  <= 1'b0;
      inf_data <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      if (load && !loaded) begin
        cl_hdr   <= fc_hdr;
        cl_data  <= fc_data;
        inf_hdr  <= (fc_hdr == '0);
        inf_data <= (fc_data == '0);
        loaded   <= 1'b1;
      end else if (upd) begin
        if (!inf_hdr)  cl_hdr  <= fc_hdr;
        if (!inf_data) cl_data <= fc_data;
      end
      if (consume) begin
        if (!inf_hdr)  cc_hdr  <= cc_hdr + req_hdr;
        if (!inf_data) cc_data <= cc_data + req_data;
      end
    end
  end

endmodule

// File: rtl/dll_rx_fc_tracker.sv
// rtl/dll_rx_fc_tracker.sv - DLL flow-control receiver and TX credit gate
// Purpose: decodes InitFC1/InitFC2/UpdateFC for P/NP/Cpl on VC0, runs the FC
//          init FSM, gates TX arbiter requests on credits, UpdateFC watchdog.
// Ports:   clk, rst_n (async, active-low); dlc_state_i (DLCMSM state);
//          bus (slave: DLLP in, TX request in, tx_grant_o out);
//          fc_init_done_o, cl_hdr_o/cl_data_o, inf_hdr_o/inf_data_o,
//          fc_timeout_o (pulse), proto_err_o (pulse)
module dll_rx_fc_tracker
  import dll_fc_pkg::*;
#(
  parameter int HDR_W     = 8,
  parameter int DATA_W    = 12,
  parameter int NUM_TYPES = 3,
  parameter int WD_CYCLES = 200000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  dlc_state_i,
  dll_rx_fc_tracker_if.slave          bus,
  output logic                        fc_init_done_o,
  output logic [NUM_TYPES*HDR_W-1:0]  cl_hdr_o,
  output logic [NUM_TYPES*DATA_W-1:0] cl_data_o,
  output logic [NUM_TYPES-1:0]        inf_hdr_o,
  output logic [NUM_TYPES-1:0]        inf_data_o,
  output logic                        fc_timeout_o,
  output logic                        proto_err_o
);

  localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WD_CYCLES > 0) ? WD_CYCLES - 1 : 0);

  fc_fsm_e state;
  logic [NUM_TYPES-1:0] seen;
  logic [NUM_TYPES-1:0] seen_next;
  logic [WD_W-1:0]      wd_cnt;

  // Decode
  logic              dllp_ok;
  logic [3:0]        dtype;
  logic [1:0]        dcls;
  logic [1:0]        didx;
  logic              type_vld;
  logic              is_init1;
  logic              is_init2;
  logic              is_upd;
  logic              upd_en;
  logic              link_down;
  logic              dl_active;
  logic [HDR_W-1:0]  fc_hdr;
  logic [DATA_W-1:0] fc_data;
  logic [NUM_TYPES-1:0] hit;

  assign dllp_ok   = bus.dllp_valid_i & bus.dllp_crc_ok_i &
                     (bus.dllp_i[DLLP_VC_MSB:DLLP_VC_LSB] == 3'd0);
  assign dtype     = bus.dllp_i[DLLP_TYPE_MSB:DLLP_TYPE_LSB];
  assign dcls      = dtype[3:2];
  assign didx      = dtype[1:0];
  assign type_vld  = dllp_ok & (didx != 2'd3);
  assign is_init1  = type_vld & (dcls == DLLP_CLS_INITFC1);
  assign is_init2  = type_vld & (dcls == DLLP_CLS_INITFC2);
  assign is_upd    = type_vld & (dcls == DLLP_CLS_UPDATEFC);
  assign fc_hdr    = HDR_W'(bus.dllp_i[HDRFC_MSB:HDRFC_LSB]);
  assign fc_data   = DATA_W'(bus.dllp_i[DATAFC_MSB:DATAFC_LSB]);
  assign link_down = (dlc_state_i == DLC_INACTIVE) | (dlc_state_i == DLC_FEATURE);
  assign dl_active = (dlc_state_i == DLC_DL_ACTIVE);
  assign upd_en    = is_upd & (state == FC_DONE) & dl_active;

  logic unused_dllp_bits;
  assign unused_dllp_bits = ^{bus.dllp_i[135:64], bus.dllp_i[59], bus.dllp_i[55:54],
                              bus.dllp_i[45:44], bus.dllp_i[31:0]};

  // Credit slots
  logic [NUM_TYPES-1:0][HDR_W-1:0]  cl_hdr;
  logic [NUM_TYPES-1:0][DATA_W-1:0] cl_data;
  logic [NUM_TYPES-1:0] inf_hdr;
  logic [NUM_TYPES-1:0] inf_data;
  logic [NUM_TYPES-1:0] loaded;
  logic [NUM_TYPES-1:0] hdr_ok;
  logic [NUM_TYPES-1:0] data_ok;
  logic [NUM_TYPES-1:0] upd_err;
  logic                 grant;

  for (genvar t = 0; t < NUM_TYPES; t++) begin : g_slot
    assign hit[t] = (didx == 2'(t));

    dll_fc_credit_slot #(
      .HDR_W  (HDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (link_down),
      .load     (is_init1 & hit[t] & (state == FC_INIT1)),
      .upd      (upd_en & hit[t]),
      .fc_hdr   (fc_hdr),
      .fc_data  (fc_data),
      .consume  (grant & (bus.tx_req_type_i == 2'(t))),
      .req_hdr  (bus.tx_req_hdr_i),
      .req_data (bus.tx_req_data_i),
      .cl_hdr   (cl_hdr[t]),
      .cl_data  (cl_data[t]),
      .inf_hdr  (inf_hdr[t]),
      .inf_data (inf_data[t]),
      .loaded   (loaded[t]),
      .hdr_ok   (hdr_ok[t]),
      .data_ok  (data_ok[t]),
      .upd_err  (upd_err[t])
    );
  end

  assign cl_hdr_o       = cl_hdr;
  assign cl_data_o      = cl_data;
  assign inf_hdr_o      = inf_hdr;
  assign inf_data_o     = inf_data;
  assign fc_init_done_o = (state == FC_DONE);

  // Grant mux: type 3 is reserved and never matches a slot.
  always_comb begin
    grant = 1'b0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (bus.tx_req_type_i == 2'(t)) grant = hdr_ok[t] & data_ok[t];
    end
    grant = grant & bus.tx_req_i & fc_init_done_o;
  end
  assign bus.tx_grant_o = grant;

  // InitFC2 and UpdateFC both count toward leaving INIT2.
  assign seen_next = seen | ({NUM_TYPES{is_init2 | is_upd}} & hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FC_IDLE;
      seen        <= '0;
      proto_err_o <= 1'b0;
    end else begin
      proto_err_o <= |upd_err;
      if (link_down) begin
        state <= FC_IDLE;
        seen  <= '0;
      end else begin
        case (state)
          FC_IDLE: begin
            if (dlc_state_i == DLC_DL_INIT) state <= FC_INIT1;
          end
          FC_INIT1: begin
            if (&loaded) state <= dl_active ? FC_DONE : FC_INIT2;
          end
          FC_INIT2: begin
            seen <= seen_next;
            if ((&seen_next) || (dl_active && (&loaded))) state <= FC_DONE;
          end
          default: state <= FC_DONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt       <= '0;
      fc_timeout_o <= 1'b0;
    end else begin
      fc_timeout_o <= 1'b0;
      if ((WD_CYCLES == 0) || (state != FC_DONE) || link_down || upd_en) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LAST) begin
        wd_cnt       <= '0;
        fc_timeout_o <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule
